// File: rtl/nz_scan_ctrl.sv
// Nonzero-scan sequencer: walks a memory window, one read per two cycles, reporting the first nonzero word.
// Optional NZ_SCAN_COUNT_EN: scan the full window and count nonzero words on nz_count.
module nz_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] found_idx,
  output logic [DATA_W-1:0] found_data
`ifdef NZ_SCAN_COUNT_EN
  ,
  output logic [ADDR_W:0]   nz_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] fidx_q, fidx_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic              word_nz, last_word, stop_early;
`ifdef NZ_SCAN_COUNT_EN
  logic [ADDR_W:0]   cnt_q, cnt_d;
`endif

  assign word_nz   = |mem_rd_data;
  assign last_word = ({1'b0, idx_q} == (len_q - LEN_ONE));

`ifdef NZ_SCAN_COUNT_EN
  assign stop_early = 1'b0;
`else
  assign stop_early = word_nz;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    found_d = found_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;
`ifdef NZ_SCAN_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d   = length;
          idx_d   = '0;
          found_d = 1'b0;
          fidx_d  = '0;
          fdata_d = '0;
`ifdef NZ_SCAN_COUNT_EN
          cnt_d   = '0;
`endif
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = base_addr;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = abort ? S_IDLE : S_CHECK;
      S_CHECK: begin
        // An abort discards the read that is landing this cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (word_nz && !found_q) begin
            found_d = 1'b1;
            fidx_d  = idx_q;
            fdata_d = mem_rd_data;
          end
`ifdef NZ_SCAN_COUNT_EN
          if (word_nz) cnt_d = cnt_q + LEN_ONE;
`endif
          if (stop_early || last_word) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ONE_A;
            addr_d  = addr_q + ONE_A;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      found_q <= 1'b0;
      fidx_q  <= '0;
      fdata_q <= '0;
`ifdef NZ_SCAN_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      found_q <= found_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
`ifdef NZ_SCAN_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem_rd_en  = (state_q == S_ISSUE);
  assign mem_addr   = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && !abort;
  assign found      = found_q;
  assign found_idx  = fidx_q;
  assign found_data = fdata_q;
`ifdef NZ_SCAN_COUNT_EN
  assign nz_count   = cnt_q;
`endif

endmodule
